// File: rtl/dual_bram_pkg.sv
// dual_bram_pkg: shared definitions for the dual_bram_be memory slice.
//   - RDW_READ_FIRST / RDW_WRITE_FIRST: same-port read-during-write policy codes
//   - state_t: controller states (zero-fill sweep, normal operation)
//   - merge_bytes(): byte-lane merge of a word under a lane mask
package dual_bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend into it
    // and truncate the result back to their own width.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  lane_mask
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (lane_mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dual_bram_port_out.sv
// dual_bram_port_out: read-data / read-valid output register stage for one
// port of dual_bram_be.
// Optional macro: DUAL_BRAM_OUTREG_EN adds a second register stage
// (read latency 2 instead of 1); the extra stage is also cleared by rst.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rd_fire            a read is being issued this cycle
//   rd_word            word to return for that read
//   r_data, r_valid    registered read data and valid
// r_data holds its last value while no read is returned.
module dual_bram_port_out
    import dual_bram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_fire,
    input  logic [DATA_W-1:0] rd_word,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid
);

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

`ifdef DUAL_BRAM_OUTREG_EN
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
            end
        end
    end

    assign r_data  = s2_data;
    assign r_valid = s2_valid;
`else
    assign r_data  = s1_data;
    assign r_valid = s1_valid;
`endif

endmodule

// File: rtl/dual_bram_be.sv
// dual_bram_be: true-dual-port word memory with per-byte write enables,
// configurable read-during-write policy, cross-port write merging and a
// hardware zero-fill sweep after reset.
// Optional macro: DUAL_BRAM_OUTREG_EN (extra read output register stage).
// Ports (N = 0, 1):
//   clk, rst               clock, asynchronous active-high reset
//   init_done              zero-fill sweep finished
//   pN_en                  access request (every enabled cycle reads)
//   pN_addr                byte address, word index = addr >> log2(bytes)
//   pN_W_req               per-byte write enable, all zero = read only
//   pN_W_data              write data
//   pN_R_data, pN_R_valid  read data and valid
//   collision              pulse: both ports wrote the same word
//   addr_err               sticky: out-of-range word index accessed
module dual_bram_be
    import dual_bram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 60001,
    parameter int ADDR_W   = 32,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    input  logic                p0_en,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W/8-1:0] p0_W_req,
    input  logic [DATA_W-1:0]   p0_W_data,
    output logic [DATA_W-1:0]   p0_R_data,
    output logic                p0_R_valid,
    input  logic                p1_en,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W/8-1:0] p1_W_req,
    input  logic [DATA_W-1:0]   p1_W_data,
    output logic [DATA_W-1:0]   p1_R_data,
    output logic                p1_R_valid,
    output logic                collision,
    output logic                addr_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BYTES-1:0]  lane_mask
    );
        return DATA_W'(merge_bytes(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word),
                                   MAX_BYTES'(lane_mask)));
    endfunction

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  cnt;
    logic              run;
    logic              sweep_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // The sweep leaves INIT on the same edge that clears the last word.
    always_comb begin
        state_nx = state;
        if (state == ST_INIT && cnt == LAST_IDX) begin
            state_nx = ST_RUN;
        end
    end

    always_comb begin
        run      = (state == ST_RUN);
        sweep_we = (state == ST_INIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sweep_we) begin
            cnt <= cnt + 1'b1;
        end
    end

    logic [ADDR_W-1:0] widx0, widx1;
    logic [IDX_W-1:0]  idx0, idx1;
    logic              in0, in1;
    logic              rd0, rd1, wr0, wr1, both_wr_same;
    logic [DATA_W-1:0] old0, old1, new0, new1, rd_word0, rd_word1;

    always_comb begin
        widx0 = p0_addr >> BSH;
        widx1 = p1_addr >> BSH;
        in0   = {1'b0, widx0} < DEPTH_X;
        in1   = {1'b0, widx1} < DEPTH_X;
        idx0  = widx0[IDX_W-1:0];
        idx1  = widx1[IDX_W-1:0];

        rd0 = run & p0_en;
        rd1 = run & p1_en;
        // Out-of-range writes are dropped, so they never reach the array.
        wr0 = rd0 & in0 & (|p0_W_req);
        wr1 = rd1 & in1 & (|p1_W_req);
        both_wr_same = wr0 & wr1 & (idx0 == idx1);

        old0 = in0 ? mem[idx0] : '0;
        old1 = in1 ? mem[idx1] : '0;

        // Same-word double write: lay port 1 down first, then port 0 on top
        // so port 0 wins every lane it enables.
        if (both_wr_same) begin
            new0 = merge_w(merge_w(old0, p1_W_data, p1_W_req), p0_W_data, p0_W_req);
            new1 = new0;
        end else begin
            new0 = merge_w(old0, p0_W_data, p0_W_req);
            new1 = merge_w(old1, p1_W_data, p1_W_req);
        end

        // Write-first returns the word as it will be stored; a port that only
        // reads always sees the pre-write contents.
        rd_word0 = (RDW_MODE == RDW_WRITE_FIRST && wr0) ? new0 : old0;
        rd_word1 = (RDW_MODE == RDW_WRITE_FIRST && wr1) ? new1 : old1;
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0) begin
                mem[idx0] <= new0;
            end
            if (wr1 && !both_wr_same) begin
                mem[idx1] <= new1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= 1'b0;
            collision <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            init_done <= run;
            collision <= both_wr_same;
            addr_err  <= addr_err | (rd0 & ~in0) | (rd1 & ~in1);
        end
    end

    dual_bram_port_out #(.DATA_W(DATA_W)) u_p0_out (
        .clk     (clk),
        .rst     (rst),
        .rd_fire (rd0),
        .rd_word (rd_word0),
        .r_data  (p0_R_data),
        .r_valid (p0_R_valid)
    );

    dual_bram_port_out #(.DATA_W(DATA_W)) u_p1_out (
        .clk     (clk),
        .rst     (rst),
        .rd_fire (rd1),
        .rd_word (rd_word1),
        .r_data  (p1_R_data),
        .r_valid (p1_R_valid)
    );

endmodule

// File: doc/dual_bram_be.md
# dual_bram_be

Parametrised true-dual-port word memory with per-byte write enables, configurable width/depth, read-during-write policy, cross-port write merging and a hardware zero-fill after reset. It is the next-generation scratch/feature-map buffer of the accelerator, shared between the DMA side (port 0) and the compute side (port 1). Both ports take byte addresses.

## Interface
Parameters:
- DATA_W, 32: word width in bits; multiple of 8.
- DEPTH, 60001: number of words.
- ADDR_W, 32: byte-address width.
- RDW_MODE, 0: same-port read-during-write policy. 0 = read-first (old data); 1 = write-first (new merged data).

Ports (N = 0, 1; BYTES = DATA_W/8):
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_done  out  1  high once the zero-fill sweep has finished.
- pN_en  in  1  port access request.
- pN_addr  in  ADDR_W  byte address; word index = pN_addr >> log2(BYTES).
- pN_W_req  in  BYTES  per-byte write enable; all zero means read.
- pN_W_data  in  DATA_W  write data.
- pN_R_data  out  DATA_W  read data.
- pN_R_valid  out  1  pN_R_data is valid this cycle.
- collision  out  1  one-cycle pulse when both ports wrote the same word.
- addr_err  out  1  sticky flag: an access was made with word index >= DEPTH.

## Operation
- States are INIT and RUN. Reset forces INIT with the sweep counter at 0.
- INIT:
  - Writes 0 to word[cnt] each cycle and increments cnt.
  - On the cycle cnt == DEPTH-1 is written, moves to RUN, and init_done rises on the next edge.
  - pN_en is ignored: no writes, pN_R_valid stays 0.
- RUN, pN_en=1:
  - Every byte lane b with pN_W_req[b]=1 is written from pN_W_data[8b+7:8b].
  - The port performs a read on every enabled cycle, whether or not it writes.
- Same-port read-during-write: pN_R_data returns the pre-write word when RDW_MODE=0, or the byte-merged new word when RDW_MODE=1.
- Cross-port access to the same word in the same cycle:
  - A read always returns the old word.
  - When both ports write, byte lanes enabled on port 0 take port 0 data. Lanes enabled only on port 1 take port 1 data.
  - collision pulses high for one cycle, on the edge after the access, whenever both ports write the same word (overlapping lanes or not).
- Out-of-range word index:
  - Writes are dropped.
  - The read returns 0 with pN_R_valid=1.
  - addr_err sets and stays set until reset.
- With pN_en=0, pN_R_data holds its last value and pN_R_valid=0.

## Timing
- Reset values: pN_R_data=0, pN_R_valid=0, init_done=0, collision=0, addr_err=0. State is INIT and cnt=0.
- Zero-fill takes DEPTH cycles after reset deassertion.
- Read latency is 1 cycle: request on edge k, data and R_valid on edge k+1. With DUAL_BRAM_OUTREG_EN the latency is 2 cycles.
- Write latency is 1 cycle: the word is visible to a read issued on edge k+1 (returned at k+2).
- Throughput is one access per port per cycle. There are no stalls in RUN.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately.
  - In-flight reads are discarded.
  - The sweep restarts from 0; memory contents are overwritten by the new sweep.

## Configuration
- DUAL_BRAM_OUTREG_EN defined: adds a second register stage on pN_R_data and pN_R_valid for timing closure.
  - Read latency becomes 2 cycles.
  - collision and addr_err timing is unchanged.
  - Reset also clears the extra stage.
- DUAL_BRAM_OUTREG_EN undefined: 1-cycle read path as described above.

## Structure
- Shared package dual_bram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - the state enum {ST_INIT, ST_RUN};
  - a function for byte-merging a word under a lane mask.
- Sub-module dual_bram_port_out, instantiated once per port: output/valid register stage(s) including the optional OUTREG stage.
- Memory array, sweep counter and collision/merge logic live in the top module.

## Test plan
- Reset, then wait DEPTH cycles: init_done rises exactly DEPTH+1 edges after rst falls. Reading word 5 then returns 0x00000000.
- RUN: p0 writes 0xDEADBEEF to byte address 0x10 with W_req=4'hF, then p1 reads 0x10. p1_R_data=0xDEADBEEF with p1_R_valid, one cycle after the read request.
- Start with word 0x10 = 0xDEADBEEF. Same edge: p0 W_req=4'h3 data 0x11112222, p1 W_req=4'hE data 0x33334444. The word becomes 0x33332222 and collision pulses once.
- Same-port read-during-write on a word holding 0xAAAAAAAA, writing 0x55555555: the port returns 0xAAAAAAAA with RDW_MODE=0 and 0x55555555 with RDW_MODE=1.
- p0 reads byte address 4*DEPTH: p0_R_data=0, p0_R_valid=1, and addr_err sets and stays set.
- Assert rst during RUN with reads in flight: all outputs go to 0 immediately, the previously written word reads 0 after the new sweep, and init_done drops then rises again after DEPTH cycles.
